bit_serializer: RTL and testbench

Parallel-to-serial front end for the 3-state sequence-detector FSM. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on OUT, which drives the detector's IN. A one-word holding register lets the next word be accepted while the current one shifts, so back-to-back words reach the detector with no idle bits between them.

---
 rtl/bit_serializer.sv | 83 ++++++++
 tb/tb_bit_serializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the sequence detector.
// One-word holding register allows gapless back-to-back words.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic [15:0]      words
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] TOP = BW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bits_left;

  assign din_ready = !hold_full;
  assign out_valid = (state == SHIFT);

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      bits_left <= '0;
      out       <= IDLE_LEVEL;
      last      <= 1'b0;
      words     <= 16'd0;
    end else begin
      if (din_valid && !hold_full) begin
        hold      <= din;
        hold_full <= 1'b1;
      end
      if (last)
        words <= words + 16'd1;
      // shifting outranks loading; load only once the word is done
      if (state == SHIFT && bits_left != '0) begin
        if (MSB_FIRST) begin
          shreg <= shreg << 1;
          out   <= shreg[WIDTH-2];
        end else begin
          shreg <= shreg >> 1;
          out   <= shreg[1];
        end
        bits_left <= bits_left - BW'(1);
        last      <= (bits_left == BW'(1));
      end else if (hold_full) begin
        shreg     <= hold;
        out       <= first_bit(hold);
        bits_left <= TOP;
        state     <= SHIFT;
        last      <= 1'b0;
        hold_full <= 1'b0;
      end else begin
        out   <= IDLE_LEVEL;
        state <= IDLE;
        last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: reset, single word,
// back-to-back, backpressure and LSB-first/idle-level.
module tb_bit_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        out;
  logic        out_valid;
  logic        last;
  logic [15:0] words;

  logic [7:0]  din1 = '0;
  logic        din_valid1 = 1'b0;
  logic        din_ready1;
  logic        out1;
  logic        out_valid1;
  logic        last1;
  logic [15:0] words1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .out(out), .out_valid(out_valid),
    .last(last), .words(words)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid1),
    .din_ready(din_ready1), .out(out1), .out_valid(out_valid1),
    .last(last1), .words(words1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_stream(input logic [7:0] w [3], input int n,
                            output logic [31:0] bits, output int nbits,
                            output int gaps, output int acc_t [3]);
    int idx;
    bit acc;
    bit started;
    bit prev;
    idx = 0;
    started = 0;
    prev = 0;
    bits = '0;
    nbits = 0;
    gaps = 0;
    for (int k = 0; k < 3; k++) acc_t[k] = -1;
    for (int cyc = 0; cyc < n * 8 + 8; cyc++) begin
      if (idx < n) begin
        din = w[idx];
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      acc = din_valid && din_ready;
      step();
      if (acc) begin
        acc_t[idx] = cyc;
        idx++;
      end
      if (out_valid) begin
        if (started && !prev) gaps++;
        started = 1;
        bits = {bits[30:0], out};
        nbits++;
      end
      prev = out_valid;
    end
    din_valid = 1'b0;
  endtask

  logic [7:0]  w [3];
  logic [31:0] bits;
  int          nbits;
  int          gaps;
  int          acc_t [3];
  logic [7:0]  pat;

  initial begin
    do_reset();

    // mid-stream asynchronous reset
    din = 8'hC3;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (4) step();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_words", 32'(words), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd1);
    check("rst_idle1", 32'(out1), 32'd1);
    repeat (3) step();
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_out", 32'(out), 32'd0);
    check("post_rst_words", 32'(words), 32'd0);
    check("post_rst_ready", 32'(din_ready), 32'd1);

    // single word 8'hE3
    pat = 8'hE3;
    din = pat;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    check("sw_ready_low", 32'(din_ready), 32'd0);
    check("sw_not_valid", 32'(out_valid), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("sw_bit%0d", k), 32'(out), 32'(pat[8-k]));
      check($sformatf("sw_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("sw_last%0d", k), 32'(last), 32'(k == 8));
      if (k == 1) check("sw_ready_back", 32'(din_ready), 32'd1);
    end
    step();
    check("sw_valid_drop", 32'(out_valid), 32'd0);
    check("sw_words", 32'(words), 32'd1);

    // back-to-back A5, 3C
    do_reset();
    w[0] = 8'hA5;
    w[1] = 8'h3C;
    w[2] = 8'h00;
    run_stream(w, 2, bits, nbits, gaps, acc_t);
    check("b2b_nbits", 32'(nbits), 32'd16);
    check("b2b_bits", bits, 32'h0000A53C);
    check("b2b_gaps", 32'(gaps), 32'd0);
    check("b2b_acc1", 32'(acc_t[1] - acc_t[0]), 32'd2);
    check("b2b_words", 32'(words), 32'd2);

    // backpressure FF, 00, FF
    do_reset();
    w[0] = 8'hFF;
    w[1] = 8'h00;
    w[2] = 8'hFF;
    run_stream(w, 3, bits, nbits, gaps, acc_t);
    check("bp_nbits", 32'(nbits), 32'd24);
    check("bp_bits", bits, 32'h00FF00FF);
    check("bp_gaps", 32'(gaps), 32'd0);
    check("bp_acc1", 32'(acc_t[1] - acc_t[0]), 32'd2);
    check("bp_acc2", 32'(acc_t[2] - acc_t[1]), 32'd8);
    check("bp_words", 32'(words), 32'd3);

    // LSB-first, idle level 1
    pat = 8'h01;
    din1 = pat;
    din_valid1 = 1'b1;
    step();
    din_valid1 = 1'b0;
    check("lsb_idle", 32'(out1), 32'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("lsb_bit%0d", k), 32'(out1), 32'(pat[k]));
      check($sformatf("lsb_valid%0d", k), 32'(out_valid1), 32'd1);
    end
    step();
    check("lsb_drop", 32'(out_valid1), 32'd0);
    check("lsb_idle_back", 32'(out1), 32'd1);
    check("lsb_words", 32'(words1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
